var_len_packer: RTL and testbench
=================================

Name: var_len_packer

Overview:
- Parametrised successor to the encoder's fixed-width shift streamer. Packs a stream of variable-length, MSB-aligned codewords (0..IN_W bits each) into a dense stream of OUT_W-bit output words.
- Supports independent input and output widths, a registered last-word marker, and padding-bit reporting for the final word.
- Sits at the tail of the encoder, between the code generators and the output stream interface.

Parameters:
- IN_W, 8, max codeword width; data_i is IN_W bits wide and len_i ranges 0..IN_W.
- OUT_W, 8, output word width; must be ≥1. IN_W > OUT_W is legal.
- BUF_W, IN_W+OUT_W, internal buffer width (localparam, not overridable).
- CNT_W, $clog2(BUF_W+1), fill-counter width (localparam).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  IN_W  codeword, MSB-aligned; bits below len_i are don't-care and are masked internally.
- len_i  in  $clog2(IN_W+1)  number of valid bits in data_i.
- flush_i  in  1  end of stream; qualified by rdy_o (with or without vld_i).
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- data_o  out  OUT_W  packed word; first bit is the MSB.
- last_o  out  1  marks the final word of a flushed stream.
- vld_o  out  1  output valid.
- rdy_i  in  1  output ready.
- idle_o  out  1  buffer empty, RUN state, no accept this cycle.

Behaviour:
- Reset values:
  - buf_q=0, cnt_q=0, state RUN.
  - Outputs: vld_o=0, last_o=0, rdy_o=1, idle_o=1, data_o=0.
- Output path:
  - data_o = buf_q[BUF_W-1 -: OUT_W] (registered).
  - A word becomes visible on the cycle after the accept that completes it.
- Handshakes:
  - pop = vld_o && rdy_i
  - avail = pop ? cnt_q-OUT_W : cnt_q (saturates at 0 for a flush pop)
  - RUN: rdy_o = (avail < OUT_W). This is a combinational rdy_i→rdy_o path and is intended.
  - Accept = vld_i && rdy_o.
  - On accept, masked data_i is right-shifted by avail and ORed below the remaining bits; cnt_d = avail + len_i.
  - The invariant cnt_q ≤ BUF_W-1 in RUN guarantees there is never an overflow.
  - vld_o in RUN = (cnt_q ≥ OUT_W).
  - On pop, the buffer shifts left by OUT_W and zero-fills.
- Simultaneous pop and accept in one cycle is required and must not produce a bubble.
- len_i=0 with vld_i: accepted, buffer unchanged.
- Flush:
  - flush_i && rdy_o → go to FLUSH after applying any accepted codeword in the same cycle.
  - If the resulting cnt is 0, stay in RUN: no word and no last_o.
- FLUSH state:
  - rdy_o=0.
  - vld_o = 1 while cnt_q > 0.
  - Each pop subtracts min(cnt_q, OUT_W).
  - last_o=1 on the word where cnt_q ≤ OUT_W; that word is zero-padded in its LSBs.
  - After that pop: cnt=0, buf=0, state RUN.
- data_o, last_o and vld_o must be held stable while vld_o && !rdy_i.
- Reset asserted mid-operation: all state is cleared immediately and any partial data is discarded.
- Assertions (simulation only):
  - len_i ≤ IN_W when vld_i.
  - cnt_q ≤ BUF_W-1.
  - Bits of buf_q below cnt_q are zero.

Optional Feature:
- Macro: EBPC_PACKER_PADCNT_EN.
- Defined: adds output pad_bits_o [$clog2(OUT_W)-1:0] = OUT_W - cnt_q when last_o=1, else 0. It is registered with data_o and stable under backpressure.
- Undefined: the port and its logic are absent; nothing else changes.

Decomposition:
- ebpc_pkg gets packer_state_t {PK_RUN, PK_FLUSH}.
- No sub-module; the buffer, counter and FSM form a single always_comb / always_ff pair.

Test Plan:
- Reset: release rst_ni → vld_o=0, rdy_o=1, idle_o=1, data_o=8'h00.
- Two 4-bit codes: (8'hA0, len 4) then (8'h50, len 4) → next cycle data_o=8'hA5, vld_o=1, last_o=0.
- Backpressure: rdy_i=0, three (8'hF8, len 5) inputs →
  - after the second accept cnt=10, rdy_o=0, data_o=8'hFF held;
  - then rdy_i=1 → word popped and third codeword accepted in the same cycle.
- Flush: (8'hA0, len 3) with flush_i →
  - data_o=8'hA0, last_o=1, pad_bits_o=5;
  - after pop: idle_o=1, rdy_o=1.
- Empty flush: flush_i with cnt=0 and vld_i=0 → no vld_o for 10 cycles, idle_o stays 1.
- Reset mid-stream: cnt=6, pulse rst_ni low → vld_o=0 immediately; subsequent (8'h3C, len 8) → data_o=8'h3C alone.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared types for the encoder back end.
// Holds the packer FSM state encoding.
package ebpc_pkg;

  typedef enum logic {
    PK_RUN,
    PK_FLUSH
  } packer_state_t;

endpackage

// File: rtl/var_len_packer.sv
// Packs MSB-aligned variable-length codewords into OUT_W-bit words.
// Define EBPC_PACKER_PADCNT_EN to add the pad_bits_o output.
module var_len_packer
  import ebpc_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IN_W-1:0]            data_i,
  input  logic [$clog2(IN_W+1)-1:0]  len_i,
  input  logic                       flush_i,
  input  logic                       vld_i,
  output logic                       rdy_o,
  output logic [OUT_W-1:0]           data_o,
  output logic                       last_o,
  output logic                       vld_o,
  input  logic                       rdy_i,
  output logic                       idle_o
`ifdef EBPC_PACKER_PADCNT_EN
  ,
  output logic [$clog2(OUT_W)-1:0]   pad_bits_o
`endif
);

  localparam int BUF_W = IN_W + OUT_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int LEN_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);

  packer_state_t    state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             run;
  logic             pop;
  logic             acc;
  logic [CNT_W-1:0] avail;
  logic [IN_W-1:0]  code_m;
  logic [BUF_W-1:0] code_ext;
  logic [BUF_W-1:0] buf_sh;

  assign run    = (state_q == PK_RUN);
  assign vld_o  = run ? (cnt_q >= OUT_C)
                      : (cnt_q != '0);
  assign last_o = !run && (cnt_q != '0)
                && (cnt_q <= OUT_C);
  assign data_o = buf_q[BUF_W-1 -: OUT_W];

  assign pop = vld_o && rdy_i;

  // A flush pop of a short final word empties the buffer.
  assign avail = !pop ? cnt_q
               : (cnt_q > OUT_C) ? cnt_q - OUT_C
               : '0;

  assign rdy_o  = run && (avail < OUT_C);
  assign acc    = vld_i && rdy_o;
  assign idle_o = run && (cnt_q == '0) && !acc;

  assign code_m   = data_i & ~({IN_W{1'b1}} >> len_i);
  assign code_ext = {code_m, {OUT_W{1'b0}}} >> avail;
  assign buf_sh   = pop ? (buf_q << OUT_W) : buf_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_sh;
    cnt_d   = avail;
    case (state_q)
      PK_RUN: begin
        if (acc) begin
          buf_d = buf_sh | code_ext;
          cnt_d = avail + CNT_W'(len_i);
        end
        if (flush_i && rdy_o && cnt_d != '0) begin
          state_d = PK_FLUSH;
        end
      end
      PK_FLUSH: begin
        if (pop && cnt_q <= OUT_C) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = PK_RUN;
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = PK_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PK_RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef EBPC_PACKER_PADCNT_EN
  localparam int PAD_W = $clog2(OUT_W);

  assign pad_bits_o = last_o
                    ? PAD_W'(OUT_C - cnt_q)
                    : '0;
`endif

`ifndef SYNTHESIS
  logic [BUF_W-1:0] low_mask;

  assign low_mask = {BUF_W{1'b1}} >> cnt_q;

  a_len : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    vld_i |-> (len_i <= LEN_W'(IN_W)));

  a_cnt : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CNT_W'(BUF_W - 1));

  a_clean : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (buf_q & low_mask) == '0);
`endif

endmodule

// File: tb/tb_var_len_packer.sv
// Directed and randomized bench for var_len_packer.
// Random phase is checked against a bit-queue reference model.
module tb_var_len_packer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic [3:0] len_i;
  logic       flush_i;
  logic       vld_i;
  logic       rdy_o;
  logic [7:0] data_o;
  logic       last_o;
  logic       vld_o;
  logic       rdy_i;
  logic       idle_o;
`ifdef EBPC_PACKER_PADCNT_EN
  logic [2:0] pad_bits_o;
`endif

  int n_vec;
  int n_err;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } wd_t;

  var_len_packer #(
    .IN_W (8),
    .OUT_W(8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data_i),
    .len_i  (len_i),
    .flush_i(flush_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .data_o (data_o),
    .last_o (last_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i),
    .idle_o (idle_o)
`ifdef EBPC_PACKER_PADCNT_EN
    ,
    .pad_bits_o(pad_bits_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic put(input logic [7:0] d,
                     input logic [3:0] l,
                     input logic v,
                     input logic f);
    data_i  = d;
    len_i   = l;
    vld_i   = v;
    flush_i = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy_i = 1'b0;
    put(8'h00, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (vld_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vld got %b want 0", vld_o);
    end
    n_vec++;
    if (rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rdy got %b want 1", rdy_o);
    end
    n_vec++;
    if (idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle got %b want 1", idle_o);
    end
    n_vec++;
    if (data_o !== 8'h00 || last_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data got %h/%b want 00/0",
               data_o, last_o);
    end
  endtask

  task automatic test_two_codes();
    rdy_i = 1'b1;
    @(negedge clk);
    put(8'hA0, 4'd4, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (idle_o !== 1'b0) begin
      n_err++;
      $display("FAIL two_idle got %b want 0", idle_o);
    end
    @(negedge clk);
    put(8'h5F, 4'd4, 1'b1, 1'b0);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (data_o !== 8'hA5 || vld_o !== 1'b1
        || last_o !== 1'b0) begin
      n_err++;
      $display("FAIL two_word got %h/%b/%b want a5/1/0",
               data_o, vld_o, last_o);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (vld_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL two_drain got vld %b idle %b want 0 1",
               vld_o, idle_o);
    end
  endtask

  task automatic test_backpressure();
    rdy_i = 1'b0;
    @(negedge clk);
    put(8'hF8, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    put(8'hF8, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    put(8'hF8, 4'd5, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (rdy_o !== 1'b0 || data_o !== 8'hFF
        || vld_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full got rdy %b data %h vld %b want 0 ff 1",
               rdy_o, data_o, vld_o);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (rdy_o !== 1'b0 || data_o !== 8'hFF
        || vld_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold got rdy %b data %h vld %b want 0 ff 1",
               rdy_o, data_o, vld_o);
    end
    rdy_i = 1'b1;
    #1;
    n_vec++;
    if (rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_popacc got rdy %b want 1", rdy_o);
    end
    @(negedge clk);
    rdy_i = 1'b0;
    put(8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (data_o !== 8'hFE || vld_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_rest got %h/%b want fe/0",
               data_o, vld_o);
    end
    rdy_i = 1'b1;
    put(8'h00, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (data_o !== 8'hFE || last_o !== 1'b1
        || vld_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_flush got %h/%b/%b want fe/1/1",
               data_o, last_o, vld_o);
    end
`ifdef EBPC_PACKER_PADCNT_EN
    n_vec++;
    if (pad_bits_o !== 3'd1) begin
      n_err++;
      $display("FAIL bp_pad got %0d want 1", pad_bits_o);
    end
`endif
    @(negedge clk);
    #1;
    n_vec++;
    if (idle_o !== 1'b1 || vld_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end got idle %b vld %b want 1 0",
               idle_o, vld_o);
    end
  endtask

  task automatic test_flush();
    rdy_i = 1'b0;
    @(negedge clk);
    put(8'hBF, 4'd3, 1'b1, 1'b1);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (data_o !== 8'hA0 || last_o !== 1'b1
          || vld_o !== 1'b1 || rdy_o !== 1'b0) begin
        n_err++;
        $display("FAIL flush_word%0d got %h/%b/%b rdy %b want a0/1/1 0",
                 k, data_o, last_o, vld_o, rdy_o);
      end
`ifdef EBPC_PACKER_PADCNT_EN
      n_vec++;
      if (pad_bits_o !== 3'd5) begin
        n_err++;
        $display("FAIL flush_pad got %0d want 5", pad_bits_o);
      end
`endif
      @(negedge clk);
    end
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    #1;
    n_vec++;
    if (idle_o !== 1'b1 || rdy_o !== 1'b1
        || vld_o !== 1'b0 || last_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_end got idle %b rdy %b vld %b last %b want 1 1 0 0",
               idle_o, rdy_o, vld_o, last_o);
    end
  endtask

  task automatic test_empty_flush();
    rdy_i = 1'b1;
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      n_vec++;
      if (vld_o !== 1'b0 || idle_o !== 1'b1) begin
        n_err++;
        $display("FAIL eflush%0d got vld %b idle %b want 0 1",
                 k, vld_o, idle_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    rdy_i = 1'b1;
    put(8'hFC, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (data_o !== 8'hFC || vld_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_part got %h/%b want fc/0",
               data_o, vld_o);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (vld_o !== 1'b0 || data_o !== 8'h00
        || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst got %h/%b idle %b want 00/0 1",
               data_o, vld_o, idle_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h3C, 4'd8, 1'b1, 1'b0);
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (data_o !== 8'h3C || vld_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_new got %h/%b want 3c/1",
               data_o, vld_o);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (vld_o !== 1'b0 || idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_end got vld %b idle %b want 0 1",
               vld_o, idle_o);
    end
  endtask

  task automatic test_random();
    bit   bq[$];
    wd_t  wq[$];
    wd_t  w;
    int   pend, pend0;
    bit   fl, fl0;
    bit   v, f;
    bit   exp_vld, exp_last, exp_rdy, exp_idle;
    bit   pop, acc;
    logic [7:0] d;
    logic [7:0] exp_d;
    int   l;

    @(negedge clk);
    rst_n = 1'b0;
    put(8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pend = 0;
    fl   = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      v = ($urandom_range(3, 0) != 0);
      f = ($urandom_range(15, 0) == 0);
      l = $urandom_range(8, 0);
      d = 8'($urandom);
      rdy_i = ($urandom_range(3, 0) != 0);
      put(d, 4'(l), v, f);
      #1;

      exp_vld  = fl ? (pend > 0) : (pend >= 8);
      exp_last = 1'b0;
      exp_d    = 8'h00;
      if (exp_vld && wq.size() > 0) begin
        exp_last = wq[0].l;
        exp_d    = wq[0].d;
      end
      n_vec++;
      if (vld_o !== exp_vld || last_o !== exp_last) begin
        n_err++;
        $display("FAIL rnd_ctl c%0d got vld %b last %b want %b %b",
                 c, vld_o, last_o, exp_vld, exp_last);
      end
      if (exp_vld) begin
        n_vec++;
        if (wq.size() == 0 || data_o !== exp_d) begin
          n_err++;
          $display("FAIL rnd_data c%0d got %h want %h (q %0d)",
                   c, data_o, exp_d, wq.size());
        end
      end
`ifdef EBPC_PACKER_PADCNT_EN
      n_vec++;
      if (pad_bits_o !== (exp_last ? 3'(8 - pend) : 3'd0)) begin
        n_err++;
        $display("FAIL rnd_pad c%0d got %0d want %0d",
                 c, pad_bits_o, exp_last ? 8 - pend : 0);
      end
`endif

      pend0 = pend;
      fl0   = fl;
      pop   = exp_vld && rdy_i;
      if (pop) begin
        pend -= (pend < 8) ? pend : 8;
        if (wq.size() > 0) void'(wq.pop_front());
        if (fl && pend == 0) fl = 1'b0;
      end
      exp_rdy = !fl0 && (pend < 8);
      n_vec++;
      if (rdy_o !== exp_rdy) begin
        n_err++;
        $display("FAIL rnd_rdy c%0d got %b want %b",
                 c, rdy_o, exp_rdy);
      end
      acc      = v && exp_rdy;
      exp_idle = !fl0 && (pend0 == 0) && !acc;
      n_vec++;
      if (idle_o !== exp_idle) begin
        n_err++;
        $display("FAIL rnd_idle c%0d got %b want %b",
                 c, idle_o, exp_idle);
      end

      if (acc) begin
        for (int k = 0; k < l; k++) bq.push_back(d[7-k]);
        pend += l;
        while (bq.size() >= 8) begin
          w.d = 8'h00;
          w.l = 1'b0;
          for (int k = 0; k < 8; k++) w.d[7-k] = bq.pop_front();
          wq.push_back(w);
        end
      end
      if (f && exp_rdy) begin
        if (bq.size() > 0) begin
          w.d = 8'h00;
          w.l = 1'b1;
          for (int k = 0; k < bq.size(); k++) w.d[7-k] = bq[k];
          wq.push_back(w);
          bq.delete();
          fl = 1'b1;
        end else if (wq.size() > 0) begin
          w = wq[wq.size()-1];
          w.l = 1'b1;
          wq[wq.size()-1] = w;
          fl = 1'b1;
        end
      end
    end
    @(negedge clk);
    put(8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_two_codes();
    test_backpressure();
    test_flush();
    test_empty_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
